des_subkey_gen: RTL and testbench
=================================

# des_subkey_gen

Sequential DES key-schedule engine. It takes the 56-bit permuted-choice-1 key (C0‖D0) and streams the sixteen 48-bit round subkeys over a valid/ready handshake. In encrypt mode it rotates left and emits K1..K16. In decrypt mode it rotates right and emits K16..K1. It sits between the PC1 permutation and the round datapath, so one key register serves both cipher directions.

## Interface
Parameters: none; all widths are fixed by DES.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new schedule; accepted only while busy=0.
- mode  input  1  0 = encrypt (K1→K16), 1 = decrypt (K16→K1); sampled with start.
- key_pc1  input  [0:55]  PC1 output; [0:27] = C0, [28:55] = D0; bit 0 = FIPS bit 1; sampled with start.
- subkey  output  [0:47]  PC-2(C,D) of the current state; subkey[0] = FIPS PC-2 bit 1.
- subkey_valid  output  1  subkey and round are valid.
- subkey_ready  input  1  consumer accepts; transfer = valid & ready.
- round  output  [3:0]  DES round number (1..16) of the current subkey.
- busy  output  1  schedule in progress.
- done  output  1  one-cycle pulse after the 16th transfer.

## Operation
- Shift schedule per round i=1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. C and D rotate independently as 28-bit values. PC-2 is per FIPS 46-3.
- States: IDLE and RUN.
- IDLE, start=1:
  - Encrypt: load C/D = key_pc1 halves rotated left by 1, and round = 1.
  - Decrypt: load C/D = key_pc1 halves unrotated (C16 = C0), and round = 16.
  - Go to RUN.
- RUN, transfer with round ≠ last (last = 16 encrypt, 1 decrypt):
  - Encrypt: round += 1, then rotate C/D left by shift(new round).
  - Decrypt: rotate C/D right by shift(current round), then round −= 1.
- RUN, transfer on the last round: go to IDLE and pulse done for 1 cycle.
- RUN, no transfer: C, D, round and subkey hold stable (backpressure).
- start while busy is ignored. key_pc1 and mode changes after capture are ignored.
- subkey is combinational PC-2 of the C/D registers. No other logic sits between the registers and the output.
- Reset values: C = D = 0, so subkey = 0. subkey_valid = 0, busy = 0, done = 0, round = 0, state = IDLE.
- Reset asserted mid-schedule aborts immediately to the reset values. No done pulse is produced.

## Timing
- subkey_valid = busy = (state == RUN), asserted the cycle after start is accepted.
- First subkey latency: 1 cycle from start.
- With subkey_ready held high: 16 consecutive transfers in cycles 1..16 after start; done = 1 in cycle 17, with busy = 0.
- A new start is accepted in the same cycle done is high.
- There is no back-to-back overlap.

## Test plan
Key 133457799BBCDFF1 gives key_pc1 = F0CCAAF556678F.
- Encrypt, ready=1, start with key_pc1 = F0CCAAF556678F → round 1 subkey 1B02EFFC7072, round 2 79AED9DBC9E5, round 16 CB3D8B0E17F5. done pulses at cycle 17.
- Decrypt, same key → round 16 subkey CB3D8B0E17F5 first, round 1 subkey 1B02EFFC7072 last. The whole sequence equals the encrypt sequence reversed.
- Backpressure:
  - Stimulus: encrypt, drop ready for 5 cycles while round = 2.
  - Response: subkey stays 79AED9DBC9E5 and round stays 2 throughout. Total transfers remain exactly 16 and done pulses once.
- Ignored inputs:
  - Stimulus: mid-run, pulse start and change key_pc1 to 0 and mode to 1.
  - Response: the schedule continues unchanged and round 16 still gives CB3D8B0E17F5.
- Reset mid-run:
  - Stimulus: assert rst at round 7.
  - Response: subkey = 0, subkey_valid = 0, busy = 0, round = 0, no done pulse. A following start runs a full correct schedule.
- Constant keys:
  - key_pc1 = 0 → all 16 subkeys 000000000000.
  - key_pc1 = FFFFFFFFFFFFFF → all subkeys FFFFFFFFFFFF, in both modes.

Source files
------------

// File: rtl/des_subkey_gen.sv
`default_nettype none
// ============================================================================
// Module      : des_subkey_gen
// Description : Sequential DES key schedule. Captures the PC-1 output
//               (C0 || D0) on start and streams the sixteen 48-bit round
//               subkeys over a valid/ready handshake. Encrypt order is
//               K1..K16 (left rotations); decrypt order is K16..K1 (right
//               rotations), so one key register serves both directions.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               start, mode       - request schedule (0 = enc, 1 = dec)
//               key_pc1[0:55]     - C0 = [0:27], D0 = [28:55], bit 0 = FIPS bit 1
//               subkey[0:47]      - PC-2 of current C/D, bit 0 = FIPS bit 1
//               subkey_valid      - subkey/round valid
//               subkey_ready      - consumer accepts (transfer = valid & ready)
//               round[3:0]        - round number of current subkey
//               busy              - schedule in progress
//               done              - one-cycle pulse after the 16th transfer
// Revision    : 1.0 - initial release
// ============================================================================
module des_subkey_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [0:55] key_pc1,
    output logic [0:47] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round,
    output logic        busy,
    output logic        done
);

    // PC-2 selection table, 1-based positions into C||D (FIPS 46-3).
    localparam int c_pc2 [0:47] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    logic [0:27] r_c;
    logic [0:27] r_d;
    // Five bits so round 16 is representable internally.
    logic [4:0]  r_round;
    logic        r_mode;
    logic        r_done;

    logic [0:55] w_cd;
    logic        w_xfer;
    logic        w_last;
    logic [4:0]  w_next_round;

    // Rotation amount applied when entering round r.
    function automatic logic [1:0] shift_of(input logic [4:0] r);
        logic [1:0] s;
        case (r)
            5'd1, 5'd2, 5'd9, 5'd16: s = 2'd1;
            default:                 s = 2'd2;
        endcase
        return s;
    endfunction

    // Index 0 is the FIPS bit 1, so "left" moves bits toward index 0.
    function automatic logic [0:27] rotl(input logic [0:27] v, input logic [1:0] n);
        return (n == 2'd2) ? {v[2:27], v[0:1]} : {v[1:27], v[0]};
    endfunction

    function automatic logic [0:27] rotr(input logic [0:27] v, input logic [1:0] n);
        return (n == 2'd2) ? {v[26:27], v[0:25]} : {v[27], v[0:26]};
    endfunction

    assign w_cd         = {r_c, r_d};
    assign w_xfer       = (r_state == ST_RUN) && subkey_ready;
    assign w_last       = r_mode ? (r_round == 5'd1) : (r_round == 5'd16);
    assign w_next_round = r_round + 5'd1;

    generate
        for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
            assign subkey[gi] = w_cd[c_pc2[gi] - 1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_c     <= '0;
            r_d     <= '0;
            r_round <= '0;
            r_mode  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode  <= mode;
                        r_state <= ST_RUN;
                        if (mode) begin
                            // Total rotation over 16 rounds is 28, so C16 = C0.
                            r_c     <= key_pc1[0:27];
                            r_d     <= key_pc1[28:55];
                            r_round <= 5'd16;
                        end else begin
                            r_c     <= rotl(key_pc1[0:27], 2'd1);
                            r_d     <= rotl(key_pc1[28:55], 2'd1);
                            r_round <= 5'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end else if (r_mode) begin
                            // Undo the rotation that produced the current round.
                            r_c     <= rotr(r_c, shift_of(r_round));
                            r_d     <= rotr(r_d, shift_of(r_round));
                            r_round <= r_round - 5'd1;
                        end else begin
                            r_c     <= rotl(r_c, shift_of(w_next_round));
                            r_d     <= rotl(r_d, shift_of(w_next_round));
                            r_round <= w_next_round;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign subkey_valid = (r_state == ST_RUN);
    assign busy         = (r_state == ST_RUN);
    assign done         = r_done;
    // Four-bit port: round 16 is presented as 4'h0 (valid distinguishes it
    // from the idle/reset value).
    assign round        = r_round[3:0];

endmodule
`default_nettype wire

// File: tb/tb_des_subkey_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_des_subkey_gen
// Description : Self-checking bench for des_subkey_gen. Expected subkeys come
//               from a direct key-schedule model (cumulative rotation of C0/D0
//               followed by PC-2 lookup).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_des_subkey_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [0:55] key_pc1 = '0;
    logic [0:47] subkey;
    logic        subkey_valid;
    logic        subkey_ready = 1'b0;
    logic [3:0]  round;
    logic        busy;
    logic        done;

    des_subkey_gen dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode         (mode),
        .key_pc1      (key_pc1),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round        (round),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    localparam logic [55:0] c_kat_key = 56'hF0CCAAF556678F;

    int c_pc2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    int c_shift [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic [47:0] seen     [16];
    logic [47:0] enc_seen [16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Subkey of round r (1..16): C0/D0 rotated left by the sum of the first
    // r shifts, then PC-2. Vector bit 55 is FIPS bit 1.
    function automatic logic [47:0] ref_subkey(input logic [55:0] k, input int r);
        int          tot;
        logic [27:0] c;
        logic [27:0] d;
        logic [55:0] cd;
        logic [47:0] o;
        tot = 0;
        for (int j = 0; j < r; j++) tot += c_shift[j];
        tot = tot % 28;
        c = k[55:28];
        d = k[27:0];
        if (tot != 0) begin
            c = (c << tot) | (c >> (28 - tot));
            d = (d << tot) | (d >> (28 - tot));
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) o[47 - i] = cd[56 - c_pc2[i]];
        return o;
    endfunction

    // One full schedule. stall_pct: random ready-low probability.
    // hold_idx: transfer index at which ready is held low for 5 cycles.
    // junk: scribble on start/mode/key_pc1 while running.
    task automatic run_sched(input logic [55:0] k, input logic dec, input int stall_pct,
                             input int hold_idx, input bit junk);
        int   idx;
        int   cyc;
        int   held;
        int   r;
        logic rdy;
        idx  = 0;
        cyc  = 0;
        held = 0;
        @(negedge clk);
        start        = 1'b1;
        mode         = dec;
        key_pc1      = k;
        subkey_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (idx < 16 && cyc < 300) begin
            r = dec ? 16 - idx : idx + 1;
            check("valid", subkey_valid, 1);
            check("busy", busy, 1);
            check("done_low", done, 0);
            check($sformatf("subkey_r%0d", r), subkey, ref_subkey(k, r));
            check($sformatf("round_r%0d", r), round, r % 16);
            seen[r - 1] = subkey;
            rdy = ($urandom_range(99) >= stall_pct);
            if (idx == hold_idx && held < 5) begin
                rdy = 1'b0;
                held++;
            end
            if (junk && idx < 15) begin
                start   = $urandom_range(1);
                mode    = 1'b1;
                key_pc1 = '0;
            end else begin
                start = 1'b0;
            end
            subkey_ready = rdy;
            if (rdy) idx++;
            cyc++;
            @(negedge clk);
        end
        start        = 1'b0;
        subkey_ready = 1'b0;
        if (idx < 16) begin
            check("timeout_transfers", idx, 16);
        end else begin
            check("done_pulse", done, 1);
            check("busy_end", busy, 0);
            check("valid_end", subkey_valid, 0);
            @(negedge clk);
            check("done_once", done, 0);
            check("idle_stays", busy, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [55:0] rk;
        int          cyc;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_subkey", subkey, 0);
        check("rst_valid", subkey_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_round", round, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

        // Known-answer encrypt
        run_sched(c_kat_key, 1'b0, 0, -1, 1'b0);
        check("kat_r1", seen[0], 48'h1B02EFFC7072);
        check("kat_r2", seen[1], 48'h79AED9DBC9E5);
        check("kat_r16", seen[15], 48'hCB3D8B0E17F5);
        for (int i = 0; i < 16; i++) enc_seen[i] = seen[i];

        // Decrypt gives the same subkeys per round, in reverse order
        run_sched(c_kat_key, 1'b1, 0, -1, 1'b0);
        for (int i = 0; i < 16; i++)
            check($sformatf("dec_vs_enc_r%0d", i + 1), seen[i], enc_seen[i]);

        // Backpressure at round 2
        run_sched(c_kat_key, 1'b0, 0, 1, 1'b0);
        check("bp_r2", seen[1], 48'h79AED9DBC9E5);

        // Ignored start/mode/key changes mid-run
        run_sched(c_kat_key, 1'b0, 20, -1, 1'b1);
        check("junk_r16", seen[15], 48'hCB3D8B0E17F5);

        // Reset mid-run at round 7
        @(negedge clk);
        start        = 1'b1;
        mode         = 1'b0;
        key_pc1      = c_kat_key;
        @(negedge clk);
        start        = 1'b0;
        subkey_ready = 1'b1;
        cyc = 0;
        while (round != 4'd7 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_r7", round, 7);
        #2 rst = 1'b1;
        #1;
        check("arst_subkey", subkey, 0);
        check("arst_valid", subkey_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_round", round, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        rst          = 1'b0;
        subkey_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("arst_no_done", done, 0);
            check("arst_idle", busy, 0);
        end
        run_sched(c_kat_key, 1'b0, 0, -1, 1'b0);

        // Constant keys
        run_sched(56'h0, 1'b0, 0, -1, 1'b0);
        run_sched(56'h0, 1'b1, 10, -1, 1'b0);
        run_sched(56'hFFFFFFFFFFFFFF, 1'b0, 0, -1, 1'b0);
        for (int i = 0; i < 16; i++) check("ones_enc", seen[i], 48'hFFFFFFFFFFFF);
        run_sched(56'hFFFFFFFFFFFFFF, 1'b1, 0, -1, 1'b0);
        for (int i = 0; i < 16; i++) check("ones_dec", seen[i], 48'hFFFFFFFFFFFF);

        // Random keys, random direction, random backpressure
        repeat (8) begin
            rk = {$urandom, $urandom};
            run_sched(rk, 1'($urandom_range(1)), 30, -1, 1'($urandom_range(1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
